// File: rtl/axi4_lite_pkg.sv
// Shared constants and types for the AXI4-Lite response router.
// Response codes and the per-channel routing FSM state encoding.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ROUTE,
    ST_DEC_WAITW,
    ST_DEC_RESP,
    ST_TO_RESP
  } route_state_e;

endpackage

// File: rtl/axi4_lite_resp_chan.sv
// One response channel (B or R): route FSM, slave timeout and mux.
// Routed responses pass straight through; local errors are held until ready.
module axi4_lite_resp_chan
  import axi4_lite_pkg::*;
#(
  parameter int SLAVE_NUM      = 2,
  parameter int PAYLOAD_WIDTH  = 0,
  parameter bit NEED_WDATA     = 1'b0,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int IDX_W          = 1,
  localparam int PW =
    (PAYLOAD_WIDTH > 0) ? PAYLOAD_WIDTH : 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          fire,
  input  logic [SLAVE_NUM-1:0]          sel,
  input  logic [IDX_W-1:0]              sel_idx,
  input  logic                          w_fire,
  input  logic [SLAVE_NUM-1:0]          s_valid,
  input  logic [SLAVE_NUM-1:0][1:0]     s_resp,
  input  logic [SLAVE_NUM-1:0][PW-1:0]  s_data,
  output logic [SLAVE_NUM-1:0]          s_ready,
  output logic                          m_valid,
  output logic [1:0]                    m_resp,
  output logic [PW-1:0]                 m_data,
  input  logic                          m_ready,
  output logic                          busy,
  output logic [IDX_W-1:0]              route_idx,
  output logic                          route_err
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 0) ?
    $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);
  localparam bit TO_EN = (TIMEOUT_CYCLES > 0);

  route_state_e     state;
  logic [CNT_W-1:0] cnt;
  logic             sel_valid;

  assign sel_valid = s_valid[route_idx];
  assign busy      = (state != ST_IDLE);

  // Route FSM: latch target on request, leave on handshake or timeout
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      route_idx <= '0;
      route_err <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (fire) begin
            cnt <= '0;
            if (sel == '0) begin
              route_err <= 1'b1;
              state     <= NEED_WDATA ?
                           ST_DEC_WAITW : ST_DEC_RESP;
            end else begin
              route_idx <= sel_idx;
              route_err <= 1'b0;
              state     <= ST_ROUTE;
            end
          end
        end
        ST_ROUTE: begin
          if (sel_valid && m_ready) begin
            state <= ST_IDLE;
          end else if (!sel_valid && TO_EN) begin
            if (cnt == CNT_LAST) state <= ST_TO_RESP;
            else cnt <= cnt + CNT_W'(1);
          end
        end
        ST_DEC_WAITW: begin
          if (w_fire) state <= ST_DEC_RESP;
        end
        ST_DEC_RESP, ST_TO_RESP: begin
          if (m_ready) begin
            state     <= ST_IDLE;
            route_err <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Response mux: slave pass-through or locally generated error
  always_comb begin
    m_valid = 1'b0;
    m_resp  = RESP_OKAY;
    m_data  = '0;
    s_ready = '0;
    unique case (state)
      ST_ROUTE: begin
        m_valid            = sel_valid;
        m_resp             = s_resp[route_idx];
        m_data             = s_data[route_idx];
        s_ready[route_idx] = m_ready;
      end
      ST_DEC_RESP: begin
        m_valid = 1'b1;
        m_resp  = RESP_DECERR;
      end
      ST_TO_RESP: begin
        m_valid = 1'b1;
        m_resp  = RESP_SLVERR;
      end
      default: ;
    endcase
  end

  // Flag handshake misuse; the FSM simply ignores it
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(fire && busy))
        else $warning("resp_chan: request while busy ignored");
      assert (!(NEED_WDATA && w_fire &&
                state != ST_DEC_WAITW))
        else $warning("resp_chan: stray w_fire ignored");
    end
  end

endmodule

// File: rtl/axi4_lite_resp_router.sv
// AXI4-Lite response router: steers slave B/R back to the master.
// One outstanding transaction per direction; busy gates AW/AR ready.
module axi4_lite_resp_router
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int SLAVE_NUM      = 2,
  parameter int TIMEOUT_CYCLES = 256,
  parameter int IDX_W =
    (SLAVE_NUM > 1) ? $clog2(SLAVE_NUM) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 aw_fire,
  input  logic [SLAVE_NUM-1:0]                 aw_slave_sel,
  input  logic [IDX_W-1:0]                     aw_sel_idx,
  input  logic                                 w_fire,
  input  logic                                 ar_fire,
  input  logic [SLAVE_NUM-1:0]                 ar_slave_sel,
  input  logic [IDX_W-1:0]                     ar_sel_idx,
  input  logic [SLAVE_NUM-1:0]                 s_bvalid,
  input  logic [SLAVE_NUM-1:0][1:0]            s_bresp,
  output logic [SLAVE_NUM-1:0]                 s_bready,
  input  logic [SLAVE_NUM-1:0]                 s_rvalid,
  input  logic [SLAVE_NUM-1:0][DATA_WIDTH-1:0] s_rdata,
  input  logic [SLAVE_NUM-1:0][1:0]            s_rresp,
  output logic [SLAVE_NUM-1:0]                 s_rready,
  output logic                                 m_bvalid,
  output logic [1:0]                           m_bresp,
  input  logic                                 m_bready,
  output logic                                 m_rvalid,
  output logic [DATA_WIDTH-1:0]                m_rdata,
  output logic [1:0]                           m_rresp,
  input  logic                                 m_rready,
  output logic                                 wr_busy,
  output logic                                 rd_busy,
  output logic [IDX_W-1:0]                     wr_route_idx,
  output logic                                 wr_route_err
);

  logic [0:0]       b_data_unused;
  logic [IDX_W-1:0] rd_idx_unused;
  logic             rd_err_unused;

  axi4_lite_resp_chan #(
    .SLAVE_NUM      (SLAVE_NUM),
    .PAYLOAD_WIDTH  (0),
    .NEED_WDATA     (1'b1),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .IDX_W          (IDX_W)
  ) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .fire      (aw_fire),
    .sel       (aw_slave_sel),
    .sel_idx   (aw_sel_idx),
    .w_fire    (w_fire),
    .s_valid   (s_bvalid),
    .s_resp    (s_bresp),
    .s_data    ('0),
    .s_ready   (s_bready),
    .m_valid   (m_bvalid),
    .m_resp    (m_bresp),
    .m_data    (b_data_unused),
    .m_ready   (m_bready),
    .busy      (wr_busy),
    .route_idx (wr_route_idx),
    .route_err (wr_route_err)
  );

  axi4_lite_resp_chan #(
    .SLAVE_NUM      (SLAVE_NUM),
    .PAYLOAD_WIDTH  (DATA_WIDTH),
    .NEED_WDATA     (1'b0),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
    .IDX_W          (IDX_W)
  ) u_r (
    .clk       (clk),
    .rst_n     (rst_n),
    .fire      (ar_fire),
    .sel       (ar_slave_sel),
    .sel_idx   (ar_sel_idx),
    .w_fire    (1'b0),
    .s_valid   (s_rvalid),
    .s_resp    (s_rresp),
    .s_data    (s_rdata),
    .s_ready   (s_rready),
    .m_valid   (m_rvalid),
    .m_resp    (m_rresp),
    .m_data    (m_rdata),
    .m_ready   (m_rready),
    .busy      (rd_busy),
    .route_idx (rd_idx_unused),
    .route_err (rd_err_unused)
  );

endmodule

// File: tb/tb_axi4_lite_resp_router.sv
// Directed bench for axi4_lite_resp_router (2 slaves, timeout 8).
// One table row per cycle: drive at negedge, compare 1ns later.
module tb_axi4_lite_resp_router;

  localparam logic [31:0] S0 = 32'h0000_5A5A;
  localparam logic [31:0] S1 = 32'hC0DE_0001;

  typedef struct packed {
    logic       rst_n;
    logic       aw_fire;
    logic [1:0] aw_sel;
    logic       aw_idx;
    logic       w_fire;
    logic       ar_fire;
    logic [1:0] ar_sel;
    logic       ar_idx;
    logic [1:0] s_bvalid;
    logic [3:0] s_bresp;
    logic [1:0] s_rvalid;
    logic [3:0] s_rresp;
    logic       m_bready;
    logic       m_rready;
  } in_t;

  typedef struct packed {
    logic        bvalid;
    logic [1:0]  bresp;
    logic [1:0]  bready;
    logic        rvalid;
    logic [1:0]  rresp;
    logic [31:0] rdata;
    logic [1:0]  rready;
    logic        wbusy;
    logic        rbusy;
    logic        werr;
    logic        widx;
  } out_t;

  typedef struct {
    string nm;
    in_t   i;
    out_t  o;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic             aw_fire, w_fire, ar_fire;
  logic [1:0]       aw_slave_sel, ar_slave_sel;
  logic [0:0]       aw_sel_idx, ar_sel_idx;
  logic [1:0]       s_bvalid, s_bready;
  logic [1:0][1:0]  s_bresp, s_rresp;
  logic [1:0]       s_rvalid, s_rready;
  logic [1:0][31:0] s_rdata;
  logic             m_bvalid, m_bready;
  logic [1:0]       m_bresp, m_rresp;
  logic             m_rvalid, m_rready;
  logic [31:0]      m_rdata;
  logic             wr_busy, rd_busy;
  logic [0:0]       wr_route_idx;
  logic             wr_route_err;

  int n_cmp = 0;
  int n_bad = 0;
  vec_t tbl[$];

  axi4_lite_resp_router #(
    .DATA_WIDTH     (32),
    .SLAVE_NUM      (2),
    .TIMEOUT_CYCLES (8)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .aw_fire      (aw_fire),
    .aw_slave_sel (aw_slave_sel),
    .aw_sel_idx   (aw_sel_idx),
    .w_fire       (w_fire),
    .ar_fire      (ar_fire),
    .ar_slave_sel (ar_slave_sel),
    .ar_sel_idx   (ar_sel_idx),
    .s_bvalid     (s_bvalid),
    .s_bresp      (s_bresp),
    .s_bready     (s_bready),
    .s_rvalid     (s_rvalid),
    .s_rdata      (s_rdata),
    .s_rresp      (s_rresp),
    .s_rready     (s_rready),
    .m_bvalid     (m_bvalid),
    .m_bresp      (m_bresp),
    .m_bready     (m_bready),
    .m_rvalid     (m_rvalid),
    .m_rdata      (m_rdata),
    .m_rresp      (m_rresp),
    .m_rready     (m_rready),
    .wr_busy      (wr_busy),
    .rd_busy      (rd_busy),
    .wr_route_idx (wr_route_idx),
    .wr_route_err (wr_route_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input in_t v);
    @(negedge clk);
    rst_n        = v.rst_n;
    aw_fire      = v.aw_fire;
    aw_slave_sel = v.aw_sel;
    aw_sel_idx   = v.aw_idx;
    w_fire       = v.w_fire;
    ar_fire      = v.ar_fire;
    ar_slave_sel = v.ar_sel;
    ar_sel_idx   = v.ar_idx;
    s_bvalid     = v.s_bvalid;
    s_bresp      = v.s_bresp;
    s_rvalid     = v.s_rvalid;
    s_rresp      = v.s_rresp;
    m_bready     = v.m_bready;
    m_rready     = v.m_rready;
    #1;
  endtask

  function automatic out_t get_out();
    out_t a;
    a.bvalid = m_bvalid;
    a.bresp  = m_bresp;
    a.bready = s_bready;
    a.rvalid = m_rvalid;
    a.rresp  = m_rresp;
    a.rdata  = m_rdata;
    a.rready = s_rready;
    a.wbusy  = wr_busy;
    a.rbusy  = rd_busy;
    a.werr   = wr_route_err;
    a.widx   = wr_route_idx;
    return a;
  endfunction

  task automatic check(input string nm, input out_t e);
    out_t a;
    a = get_out();
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, a, e);
    end
  endtask

  task automatic chk_int(input string nm,
                         input int a, input int e);
    n_cmp++;
    if (a != e) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", nm, a, e);
    end
  endtask

  task automatic add(input string nm,
                     input in_t i, input out_t o);
    vec_t v;
    v.nm = nm;
    v.i  = i;
    v.o  = o;
    tbl.push_back(v);
  endtask

  localparam in_t NOP =
    '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  localparam in_t RST =
    '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  localparam out_t Z0 =
    '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
  localparam out_t Z1 =
    '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

  initial begin
    in_t  t;
    int   k_seen;

    s_rdata = {S1, S0};
    drive(RST);
    drive(RST);
    check("reset", Z0);

    // routed write to slave1, bvalid after 3 cycles
    add("aw_route", '{1,1,2'b10,1,0,0,0,0,0,0,0,0,1,0}, Z0);
    for (int n = 0; n < 3; n++)
      add("w_route_wait",
          '{1,0,0,0,0,0,0,0,0,0,0,0,1,0},
          '{0,0,2'b10,0,0,0,0,1,0,0,1});
    add("w_route_resp",
        '{1,0,0,0,0,0,0,0,2'b10,0,0,0,1,0},
        '{1,0,2'b10,0,0,0,0,1,0,0,1});
    add("w_route_done", NOP, Z1);
    // unmapped write: DECERR only after w_fire
    add("aw_unmapped", '{1,1,0,0,0,0,0,0,0,0,0,0,0,0}, Z1);
    add("w_dec_wait",
        '{1,0,0,0,0,0,0,0,0,0,0,0,1,0},
        '{0,0,0,0,0,0,0,1,0,1,1});
    add("w_dec_wfire",
        '{1,0,0,0,1,0,0,0,0,0,0,0,0,0},
        '{0,0,0,0,0,0,0,1,0,1,1});
    for (int n = 0; n < 4; n++)
      add("w_dec_hold", NOP,
          '{1,2'b11,0,0,0,0,0,1,0,1,1});
    add("w_dec_hs",
        '{1,0,0,0,0,0,0,0,0,0,0,0,1,0},
        '{1,2'b11,0,0,0,0,0,1,0,1,1});
    add("w_dec_done", NOP, Z1);
    // unmapped read
    add("ar_unmapped", '{1,0,0,0,0,1,0,0,0,0,0,0,0,0}, Z1);
    add("r_dec_resp",
        '{1,0,0,0,0,0,0,0,0,0,0,0,0,1},
        '{0,0,0,1,2'b11,0,0,0,1,0,1});
    add("r_dec_done",
        '{1,0,0,0,0,0,0,0,0,0,0,0,0,1}, Z1);
    // routed write + DECERR read in the same cycle
    add("conc_issue",
        '{1,1,2'b01,0,0,1,0,0,0,0,0,0,1,0}, Z1);
    add("conc_both",
        '{1,0,0,0,0,0,0,0,2'b01,4'b0001,0,0,1,0},
        '{1,2'b01,2'b01,1,2'b11,0,0,1,1,0,0});
    add("conc_rd_only",
        '{1,0,0,0,0,0,0,0,0,0,0,0,0,1},
        '{0,0,0,1,2'b11,0,0,0,1,0,0});
    add("conc_done", NOP, Z0);
    // multi-hot select: sel_idx wins
    add("aw_multihot",
        '{1,1,2'b11,1,0,0,0,0,0,0,0,0,1,0}, Z0);
    add("multihot_resp",
        '{1,0,0,0,0,0,0,0,2'b11,4'b0100,0,0,1,0},
        '{1,2'b01,2'b10,0,0,0,0,1,0,0,1});
    add("multihot_done", NOP, Z1);
    // second aw_fire while busy is ignored
    add("aw_gate_1",
        '{1,1,2'b10,1,0,0,0,0,0,0,0,0,0,0}, Z1);
    add("aw_gate_2",
        '{1,1,2'b01,0,0,0,0,0,0,0,0,0,0,0},
        '{0,0,0,0,0,0,0,1,0,0,1});
    add("gate_stall",
        '{1,0,0,0,0,0,0,0,2'b10,4'b1000,0,0,0,0},
        '{1,2'b10,2'b00,0,0,0,0,1,0,0,1});
    add("gate_hs",
        '{1,0,0,0,0,0,0,0,2'b10,4'b1000,0,0,1,0},
        '{1,2'b10,2'b10,0,0,0,0,1,0,0,1});
    add("gate_done", NOP, Z1);
    // routed read from slave1
    add("ar_route", '{1,0,0,0,0,1,2'b10,1,0,0,0,0,0,0}, Z1);
    add("r_route_stall",
        '{1,0,0,0,0,0,0,0,0,0,2'b10,4'b0100,0,0},
        '{0,0,0,1,2'b01,S1,2'b00,0,1,0,1});
    add("r_route_hs",
        '{1,0,0,0,0,0,0,0,0,0,2'b10,4'b0100,0,1},
        '{0,0,0,1,2'b01,S1,2'b10,0,1,0,1});
    add("r_route_done", NOP, Z1);

    foreach (tbl[n]) begin
      drive(tbl[n].i);
      check(tbl[n].nm, tbl[n].o);
    end

    // read timeout: 8 silent cycles in ROUTE, SLVERR on the 9th
    t = NOP; t.ar_fire = 1; t.ar_sel = 2'b01;
    drive(t);
    t = NOP;
    k_seen = 0;
    for (int k = 1; k <= 20; k++) begin
      drive(t);
      if (m_rvalid === 1'b1) begin
        k_seen = k;
        break;
      end
    end
    chk_int("timeout_latency", k_seen, 9);
    check("timeout_resp", '{0,0,0,1,2'b10,0,0,0,1,0,1});
    t.s_rvalid = 2'b01; t.m_rready = 1;
    drive(t);
    check("timeout_late_rvalid",
          '{0,0,0,1,2'b10,0,2'b00,0,1,0,1});
    drive(t);
    check("timeout_done", Z1);

    // reset in the middle of a routed write
    t = NOP; t.aw_fire = 1; t.aw_sel = 2'b01;
    drive(t);
    drive(NOP);
    check("rst_pre", '{0,0,0,0,0,0,0,1,0,0,0});
    t = NOP; t.rst_n = 0;
    drive(t);
    t = NOP; t.s_bvalid = 2'b01; t.m_bready = 1;
    drive(t);
    check("rst_post", Z0);
    t.aw_fire = 1; t.aw_sel = 2'b10; t.aw_idx = 1;
    drive(t);
    t = NOP; t.s_bvalid = 2'b10; t.m_bready = 1;
    drive(t);
    check("rst_fresh", '{1,0,2'b10,0,0,0,0,1,0,0,1});
    drive(NOP);
    check("rst_done", Z1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
